// File: rtl/keccak_theta_pkg.sv
// Shared types and helpers for the streaming Keccak theta step.
// Slice bit mapping is 5*y+x, parity vectors are indexed by x.
// Holds the FSM state encoding used by theta_stream_unit.
package keccak_theta_pkg;

    localparam int SLICE_W = 25;
    localparam int PLANE   = 5;

    typedef logic [SLICE_W-1:0] slice_t;
    typedef logic [PLANE-1:0]   par_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    function automatic int bit_idx(input int x, input int y);
        return PLANE * y + x;
    endfunction

    // slice ^ D(c, p), where D[x] = c[x-1] ^ p[x+1] (indices mod 5),
    // broadcast over all five rows y.
    function automatic slice_t theta_mix(input slice_t s, input par_t c, input par_t p);
        slice_t r;
        logic   d;
        r = s;
        for (int x = 0; x < PLANE; x++) begin
            d = c[(x + PLANE - 1) % PLANE] ^ p[(x + 1) % PLANE];
            for (int y = 0; y < PLANE; y++) begin
                r[bit_idx(x, y)] = s[bit_idx(x, y)] ^ d;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/theta_col_parity.sv
// Column parity of one 25-bit slice: par_o[x] = XOR over y of slice_i[5*y+x].
// Ports: slice_i (slice_t in), par_o (par_t out).
// Purely combinational, zero latency, no flow control.
module theta_col_parity
    import keccak_theta_pkg::*;
(
    input  slice_t slice_i,
    output par_t   par_o
);

    always_comb begin
        par_o = '0;
        for (int x = 0; x < PLANE; x++) begin
            for (int y = 0; y < PLANE; y++) begin
                par_o[x] = par_o[x] ^ slice_i[bit_idx(x, y)];
            end
        end
    end

endmodule

// File: rtl/theta_stream_unit.sv
// Streaming Keccak theta over one 25-bit depth slice per beat; slice 0 is held
// and emitted last so the C[x+1][DEPTH-1] wrap term is available.
// Latency: a slice is on out_valid the cycle after acceptance; 1-deep output register.
// Backpressure: in_ready = !out_valid | out_ready while streaming, 0 while flushing slice 0.
// Ports: clk, rst (sync, active-high), theta_en, in_valid/in_ready/in_slice,
//        out_valid/out_ready/out_slice/out_z/out_last, busy.
// Optional: define THETA_PARITY_OUT_EN to add out_par (column parity of the original slice).
module theta_stream_unit
    import keccak_theta_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int DEPTH_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               theta_en,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [24:0]        in_slice,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [24:0]        out_slice,
    output logic [DEPTH_W-1:0] out_z,
    output logic               out_last,
`ifdef THETA_PARITY_OUT_EN
    output logic [4:0]         out_par,
`endif
    output logic               busy
);

    localparam logic [DEPTH_W-1:0] Z_LAST = DEPTH_W'(DEPTH - 1);
    localparam logic [DEPTH_W-1:0] Z_ONE  = DEPTH_W'(1);

    state_t               state_q, state_d;
    logic [DEPTH_W-1:0]   z_cnt_q, z_cnt_d;
    slice_t               slice0_q, slice0_d;
    par_t                 c0_q, c0_d;
    par_t                 prevc_q, prevc_d;
    logic                 mode_q, mode_d;
    logic                 out_vld_q, out_vld_d;
    slice_t               out_slice_q, out_slice_d;
    logic [DEPTH_W-1:0]   out_z_q, out_z_d;
    logic                 out_last_q, out_last_d;
    logic                 busy_q, busy_d;
    par_t                 out_par_q, out_par_d;

    par_t                 col_par;
    logic                 slot_free;
    logic                 in_acc;

    theta_col_parity u_col_parity (
        .slice_i (in_slice),
        .par_o   (col_par)
    );

    // Output slot can take a new beat when empty or draining this cycle.
    assign slot_free = !out_vld_q || out_ready;

    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE:    in_ready = 1'b1;
                STREAM:  in_ready = slot_free;
                default: in_ready = 1'b0;
            endcase
        end
    end

    assign in_acc = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        z_cnt_d     = z_cnt_q;
        slice0_d    = slice0_q;
        c0_d        = c0_q;
        prevc_d     = prevc_q;
        mode_d      = mode_q;
        out_vld_d   = out_vld_q;
        out_slice_d = out_slice_q;
        out_z_d     = out_z_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        out_par_d   = out_par_q;

        if (out_vld_q && out_ready) begin
            out_vld_d  = 1'b0;
            out_last_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (in_acc) begin
                    slice0_d = in_slice;
                    c0_d     = col_par;
                    prevc_d  = col_par;
                    mode_d   = theta_en;
                    z_cnt_d  = Z_ONE;
                    busy_d   = 1'b1;
                    state_d  = STREAM;
                end
            end
            STREAM: begin
                if (in_acc) begin
                    out_vld_d   = 1'b1;
                    out_slice_d = mode_q ? theta_mix(in_slice, col_par, prevc_q) : in_slice;
                    out_z_d     = z_cnt_q;
                    out_par_d   = col_par;
                    prevc_d     = col_par;
                    if (z_cnt_q == Z_LAST) begin
                        z_cnt_d = '0;
                        state_d = FLUSH;
                    end else begin
                        z_cnt_d = z_cnt_q + Z_ONE;
                    end
                end
            end
            FLUSH: begin
                // out_last_q marks that held slice 0 already sits in the output register;
                // prevc_q now holds C[DEPTH-1] for the wrap term.
                if (!out_last_q) begin
                    if (slot_free) begin
                        out_vld_d   = 1'b1;
                        out_slice_d = mode_q ? theta_mix(slice0_q, c0_q, prevc_q) : slice0_q;
                        out_z_d     = '0;
                        out_last_d  = 1'b1;
                        out_par_d   = c0_q;
                    end
                end else if (out_vld_q && out_ready) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            z_cnt_q     <= '0;
            slice0_q    <= '0;
            c0_q        <= '0;
            prevc_q     <= '0;
            mode_q      <= 1'b0;
            out_vld_q   <= 1'b0;
            out_slice_q <= '0;
            out_z_q     <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_par_q   <= '0;
        end else begin
            state_q     <= state_d;
            z_cnt_q     <= z_cnt_d;
            slice0_q    <= slice0_d;
            c0_q        <= c0_d;
            prevc_q     <= prevc_d;
            mode_q      <= mode_d;
            out_vld_q   <= out_vld_d;
            out_slice_q <= out_slice_d;
            out_z_q     <= out_z_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            out_par_q   <= out_par_d;
        end
    end

    assign out_valid = out_vld_q;
    assign out_slice = out_slice_q;
    assign out_z     = out_z_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;

`ifdef THETA_PARITY_OUT_EN
    assign out_par = out_par_q;
`else
    // Registered parity only feeds the optional port.
    logic unused_par;
    assign unused_par = ^out_par_q;
`endif

endmodule

// File: tb/tb_theta_stream_unit.sv
// Directed bench for theta_stream_unit (DEPTH=64).
// Drives inputs just after the rising edge, samples on the falling edge.
// Expected slices come from hand constants or a full-state theta reference.
module tb_theta_stream_unit;

    localparam int DEPTH   = 64;
    localparam int DEPTH_W = 6;
    localparam logic [24:0] COL0 = 25'h0108421;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               theta_en = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [24:0]        in_slice = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [24:0]        out_slice;
    logic [DEPTH_W-1:0] out_z;
    logic               out_last;
    logic               busy;
`ifdef THETA_PARITY_OUT_EN
    logic [4:0]         out_par;
`endif

    int total = 0;
    int bad   = 0;

    logic [24:0] frame   [DEPTH];
    logic [24:0] exp_mem [DEPTH];
    logic [4:0]  cpar    [DEPTH];

    theta_stream_unit #(.DEPTH(DEPTH), .DEPTH_W(DEPTH_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .theta_en  (theta_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_slice  (in_slice),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_slice (out_slice),
        .out_z     (out_z),
        .out_last  (out_last),
`ifdef THETA_PARITY_OUT_EN
        .out_par   (out_par),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    // Full-state theta reference: A' = A ^ C[x-1][z] ^ C[x+1][z-1].
    task automatic build_model();
        for (int z = 0; z < DEPTH; z++) begin
            for (int x = 0; x < 5; x++) begin
                cpar[z][x] = 1'b0;
                for (int y = 0; y < 5; y++) cpar[z][x] = cpar[z][x] ^ frame[z][5*y+x];
            end
        end
        for (int z = 0; z < DEPTH; z++) begin
            for (int x = 0; x < 5; x++) begin
                for (int y = 0; y < 5; y++) begin
                    exp_mem[z][5*y+x] = frame[z][5*y+x] ^ cpar[z][(x+4)%5]
                                      ^ cpar[(z+DEPTH-1)%DEPTH][(x+1)%5];
                end
            end
        end
    endtask

    task automatic clear_frame();
        for (int z = 0; z < DEPTH; z++) begin
            frame[z]   = '0;
            exp_mem[z] = '0;
        end
    endtask

    task automatic rand_frame();
        for (int z = 0; z < DEPTH; z++) frame[z] = 25'($urandom);
    endtask

    // Entered just after a rising edge. abort_at >= 0 stops after that many input beats.
    task automatic run_frame(input logic en, input bit rnd, input int abort_at);
        int          idx = 0;
        int          nout = 0;
        int          exp_z;
        bit          stall_prev = 1'b0;
        bit          acc;
        logic [24:0] prev_slice = '0;
        logic [DEPTH_W-1:0] prev_z = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (nout >= DEPTH) break;
            if (abort_at >= 0 && idx >= abort_at) break;
            #1;
            theta_en  = en;
            in_valid  = (idx < DEPTH);
            in_slice  = (idx < DEPTH) ? frame[idx] : '0;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (stall_prev) begin
                chk("hold_vld", 32'(out_valid), 32'd1);
                chk("hold_slice", 32'(out_slice), 32'(prev_slice));
                chk("hold_z", 32'(out_z), 32'(prev_z));
            end
            if (out_valid && out_ready) begin
                exp_z = (nout < DEPTH-1) ? nout + 1 : 0;
                chk("out_z", 32'(out_z), 32'(exp_z));
                chk("out_slice", 32'(out_slice), 32'(exp_mem[exp_z]));
                chk("out_last", 32'(out_last), (nout == DEPTH-1) ? 32'd1 : 32'd0);
                chk("busy_mid", 32'(busy), 32'd1);
                nout++;
            end
            stall_prev = out_valid && !out_ready;
            prev_slice = out_slice;
            prev_z     = out_z;
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) idx++;
        end
        in_valid = 1'b0;
        if (abort_at < 0) begin
            if (nout < DEPTH) chk("frame_timeout", 32'(nout), 32'(DEPTH));
            #1;
            chk("busy_end", 32'(busy), 32'd0);
            chk("vld_end", 32'(out_valid), 32'd0);
            chk("rdy_end", 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_vld", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_slice", 32'(out_slice), 32'd0);
        chk("rst_z", 32'(out_z), 32'd0);
        chk("rst_rdy", 32'(in_ready), 32'd1);
        @(posedge clk);

        // 1: zero state
        clear_frame();
        run_frame(1'b1, 1'b0, -1);

        // 2: single bit (0,0,0). C[0][0]=1 feeds column x=1 at z=0 and column x=4 at z=1.
        clear_frame();
        frame[0]   = 25'h0000001;
        exp_mem[0] = 25'h0000001 ^ (COL0 << 1);
        exp_mem[1] = COL0 << 4;
        run_frame(1'b1, 1'b0, -1);

        // 3: wrap, bit (1,0,63)
        clear_frame();
        frame[63]   = 25'h0000002;
        exp_mem[0]  = 25'h0108421;
        exp_mem[63] = 25'h0421086;
        run_frame(1'b1, 1'b0, -1);

        // 4: pass-through
        rand_frame();
        for (int z = 0; z < DEPTH; z++) exp_mem[z] = frame[z];
        run_frame(1'b0, 1'b0, -1);

        // 5: three back-to-back frames under random backpressure
        for (int f = 0; f < 3; f++) begin
            rand_frame();
            build_model();
            run_frame(1'b1, 1'b1, -1);
        end

        // 6: reset mid-frame, then a clean frame
        rand_frame();
        build_model();
        run_frame(1'b1, 1'b0, 30);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_vld", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rdy", 32'(in_ready), 32'd1);
        @(posedge clk);
        rand_frame();
        build_model();
        run_frame(1'b1, 1'b1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
